alu_mdu: RTL and testbench

Parametrised next-generation execute-stage unit for the MIPS datapath. It keeps the single-cycle integer ALU operations and adds a multi-cycle multiply/divide unit that writes HI/LO registers. While a multiply or divide is in progress it raises `busy`, which the hazard unit uses to stall. It sits in the EX stage; `result` feeds the EX/MEM register.

---
 rtl/alu_mdu.sv | 195 +++++++++++++++++++
 tb/tb_alu_mdu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage integer ALU plus a multi-cycle multiply/divide unit
// that writes the HI/LO registers.
//   clk, reset_n    : clock, synchronous active-low reset
//   A, B, shamt     : operands and shift amount
//   alu_op, start   : operation select; start qualifies MDU ops
//   result, zero,
//   overflow        : combinational ALU outputs
//   busy            : multiply/divide in flight (hazard unit stalls on it)
//   hi, lo          : HI/LO registers
module alu_mdu #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SHAMT_W     = 5,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [4:0]         alu_op,
  input  logic               start,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned HALF    = WIDTH / 2;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_OR    = 5'd2;
  localparam logic [4:0] OP_SLT   = 5'd3;
  localparam logic [4:0] OP_LUI   = 5'd4;
  localparam logic [4:0] OP_SLL   = 5'd5;
  localparam logic [4:0] OP_AND   = 5'd6;
  localparam logic [4:0] OP_XOR   = 5'd7;
  localparam logic [4:0] OP_NOR   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_SRL   = 5'd10;
  localparam logic [4:0] OP_SRA   = 5'd11;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV   = 5'd18;
  localparam logic [4:0] OP_DIVU  = 5'd19;
  localparam logic [4:0] OP_MTHI  = 5'd20;
  localparam logic [4:0] OP_MTLO  = 5'd21;
  localparam logic [4:0] OP_MFHI  = 5'd22;
  localparam logic [4:0] OP_MFLO  = 5'd23;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sgn_q;

  logic               is_mul_op, is_div_op;
  logic               launch, wr_prod, wr_div, wr_mthi, wr_mtlo;

  logic [WIDTH-1:0]   sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, uquo, urem, quo, rem;

  // ---------------- combinational ALU ----------------
  assign sum  = A + B;
  assign diff = A - B;
  assign zero = (A == B);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op)
      OP_ADD: begin
        result   = sum;
        overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        result   = diff;
        overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_OR:   result = A | B;
      OP_SLT:  result = WIDTH'($signed(A) < $signed(B));
      OP_LUI:  result = B << HALF;
      OP_SLL:  result = B << shamt;
      OP_AND:  result = A & B;
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_SLTU: result = WIDTH'(A < B);
      OP_SRL:  result = B >> shamt;
      OP_SRA:  result = $unsigned($signed(B) >>> shamt);
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end

  // ---------------- MDU control FSM ----------------
  assign is_mul_op = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
  assign is_div_op = (alu_op == OP_DIV)  || (alu_op == OP_DIVU);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; start is only honoured while idle
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && is_mul_op)      state_next = S_MUL;
        else if (start && is_div_op) state_next = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (cnt == CNT_W'(1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control strobes for the datapath
  always_comb begin
    launch  = 1'b0;
    wr_prod = 1'b0;
    wr_div  = 1'b0;
    wr_mthi = 1'b0;
    wr_mtlo = 1'b0;
    case (state)
      S_IDLE: begin
        launch  = start && (is_mul_op || is_div_op);
        wr_mthi = start && (alu_op == OP_MTHI);
        wr_mtlo = start && (alu_op == OP_MTLO);
      end
      S_MUL: wr_prod = (cnt == CNT_W'(1));
      S_DIV: wr_div  = (cnt == CNT_W'(1)) && (b_q != '0);
      default: ;
    endcase
  end

  // ---------------- MDU datapath ----------------
  // Sign-extend (or zero-extend) to 2*WIDTH so one multiplier serves both forms.
  assign prod = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q} * {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // follows the dividend. MIN/-1 wraps back to MIN with remainder 0.
  assign a_neg = sgn_q & a_q[WIDTH-1];
  assign b_neg = sgn_q & b_q[WIDTH-1];
  assign a_mag = a_neg ? (~a_q + WIDTH'(1)) : a_q;
  assign b_mag = b_neg ? (~b_q + WIDTH'(1)) : b_q;
  assign uquo  = (b_mag == '0) ? '0 : (a_mag / b_mag);
  assign urem  = (b_mag == '0) ? '0 : (a_mag % b_mag);
  assign quo   = (a_neg ^ b_neg) ? (~uquo + WIDTH'(1)) : uquo;
  assign rem   = a_neg ? (~urem + WIDTH'(1)) : urem;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      busy <= (state_next != S_IDLE);
      if (launch) begin
        a_q   <= A;
        b_q   <= B;
        sgn_q <= (alu_op == OP_MULT) || (alu_op == OP_DIV);
        cnt   <= is_mul_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (wr_mthi) hi <= A;
      if (wr_mtlo) lo <= A;
      if (wr_prod) begin
        hi <= prod[2*WIDTH-1:WIDTH];
        lo <= prod[WIDTH-1:0];
      end
      if (wr_div) begin
        hi <= rem;
        lo <= quo;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized self-checking bench for alu_mdu against a cycle-level
// arithmetic reference model (HI/LO, busy countdown, pending result).
module tb_alu_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] A, B;
  logic [4:0]  shamt;
  logic [4:0]  alu_op;
  logic        start;
  logic [31:0] result, hi, lo;
  logic        zero, overflow, busy;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_valid = 1'b0;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left = 0;
  bit          p_we = 1'b0;

  alu_mdu #(.WIDTH(32), .SHAMT_W(5), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .shamt(shamt), .alu_op(alu_op),
    .start(start), .result(result), .zero(zero), .overflow(overflow), .busy(busy),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a | b;
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return {b[15:0], 16'h0000};
      5'd5:  return b << sh;
      5'd6:  return a & b;
      5'd7:  return a ^ b;
      5'd8:  return ~(a | b);
      5'd9:  return (a < b) ? 32'd1 : 32'd0;
      5'd10: return b >> sh;
      5'd11: return 32'(sb >>> sh);
      5'd22: return m_hi;
      5'd23: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint s;
    sa = a;
    sb = b;
    if (op == 5'd0)      s = longint'(sa) + longint'(sb);
    else if (op == 5'd1) s = longint'(sa) - longint'(sb);
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Apply inputs mid-cycle and compare every output with the model.
  task automatic drive(input logic rn, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] op, input logic st);
    @(negedge clk);
    reset_n = rn; A = a; B = b; shamt = sh; alu_op = op; start = st;
    #1;
    if (m_valid) begin
      check("result",   {32'h0, result}, {32'h0, ref_res(op, a, b, sh)});
      check("zero",     {63'h0, zero}, {63'h0, a == b});
      check("overflow", {63'h0, overflow}, {63'h0, ref_ovf(op, a, b)});
      check("busy",     {63'h0, busy}, {63'h0, m_left > 0});
      check("hi",       {32'h0, hi}, {32'h0, m_hi});
      check("lo",       {32'h0, lo}, {32'h0, m_lo});
    end
  endtask

  // Advance the model across one rising edge using the applied inputs.
  task automatic tick();
    longint      sa, sb, q, r;
    longint unsigned ua, ub, up;
    int          ia, ib;
    @(posedge clk);
    ia = A; ib = B;
    sa = ia; sb = ib;
    ua = {32'h0, A}; ub = {32'h0, B};
    if (!reset_n) begin
      m_valid = 1'b1;
      m_hi = 0; m_lo = 0; m_left = 0; p_we = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_we) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (start) begin
      case (alu_op)
        5'd16: begin q = sa * sb; p_hi = q[63:32]; p_lo = q[31:0]; p_we = 1; m_left = MULT_N; end
        5'd17: begin up = ua * ub; p_hi = up[63:32]; p_lo = up[31:0]; p_we = 1; m_left = MULT_N; end
        5'd18: begin
          p_we = (B != 0); m_left = DIV_N;
          if (p_we) begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
        end
        5'd19: begin
          p_we = (B != 0); m_left = DIV_N;
          if (p_we) begin up = ua / ub; p_lo = up[31:0]; up = ua % ub; p_hi = up[31:0]; end
        end
        5'd20: m_hi = A;
        5'd21: m_lo = A;
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic rn, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [4:0] op, input logic st);
    drive(rn, a, b, sh, op, st);
    tick();
  endtask

  // Launch an MDU op, check busy for n cycles, then the resulting HI/LO.
  task automatic run_mdu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] ehi, input logic [31:0] elo);
    cyc(1'b1, a, b, 5'd0, op, 1'b1);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, $urandom, $urandom, 5'd0, 5'd0, 1'b0);
      check("mdu_busy", {63'h0, busy}, 64'd1);
      tick();
    end
    drive(1'b1, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    check("mdu_done", {63'h0, busy}, 64'd0);
    check("mdu_hi", {32'h0, hi}, {32'h0, ehi});
    check("mdu_lo", {32'h0, lo}, {32'h0, elo});
    tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; A = '0; B = '0; shamt = '0; alu_op = '0; start = 1'b0;
    cyc(1'b0, 0, 0, 0, 0, 0);
    cyc(1'b0, 0, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0);
    check("rst_hi", {32'h0, hi}, 64'd0);
    check("rst_lo", {32'h0, lo}, 64'd0);
    check("rst_busy", {63'h0, busy}, 64'd0);
    tick();

    // ALU regression
    drive(1'b1, 32'h7FFF_FFFF, 32'h1, 0, 5'd0, 0);
    check("add_res", {32'h0, result}, 64'h8000_0000);
    check("add_ovf", {63'h0, overflow}, 64'd1);
    tick();
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 0, 5'd3, 0);
    check("slt", {32'h0, result}, 64'd1);
    tick();
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 0, 5'd9, 0);
    check("sltu", {32'h0, result}, 64'd0);
    tick();
    drive(1'b1, 32'h0, 32'h8000_0000, 5'd4, 5'd11, 0);
    check("sra", {32'h0, result}, 64'hF800_0000);
    tick();
    drive(1'b1, 32'h0, 32'h1234, 0, 5'd4, 0);
    check("lui", {32'h0, result}, 64'h1234_0000);
    tick();

    // Multiply / divide
    run_mdu(5'd16, 32'hFFFF_FFFE, 32'd3, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_mdu(5'd17, 32'hFFFF_FFFE, 32'd3, MULT_N, 32'h0000_0002, 32'hFFFF_FFFA);
    run_mdu(5'd18, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_mdu(5'd19, 32'd7, 32'd2, DIV_N, 32'd1, 32'd3);
    cyc(1'b1, 32'h11, 0, 0, 5'd20, 1);
    cyc(1'b1, 32'h22, 0, 0, 5'd21, 1);
    run_mdu(5'd18, 32'd5, 32'd0, DIV_N, 32'h11, 32'h22);
    run_mdu(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0, 32'h8000_0000);

    // Busy interlock
    cyc(1'b1, 32'd3, 32'd4, 0, 5'd16, 1);
    cyc(1'b1, 32'h55, 0, 0, 5'd21, 1);
    cyc(1'b1, 32'd9, 32'd2, 0, 5'd18, 1);
    for (int i = 0; i < MULT_N - 2; i++) cyc(1'b1, 0, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0);
    check("ilock_busy", {63'h0, busy}, 64'd0);
    check("ilock_lo", {32'h0, lo}, 64'd12);
    tick();
    cyc(1'b1, 32'hAB, 0, 0, 5'd20, 1);
    drive(1'b1, 0, 0, 0, 5'd22, 0);
    check("mfhi", {32'h0, result}, 64'hAB);
    check("mthi_busy", {63'h0, busy}, 64'd0);
    tick();

    // Reset mid-divide on busy cycle 4
    cyc(1'b1, 32'd100, 32'd7, 0, 5'd18, 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 0, 0, 0, 0, 0);
    cyc(1'b0, 0, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0);
    check("rstmid_busy", {63'h0, busy}, 64'd0);
    check("rstmid_hi", {32'h0, hi}, 64'd0);
    check("rstmid_lo", {32'h0, lo}, 64'd0);
    tick();
    for (int i = 0; i < DIV_N + 2; i++) cyc(1'b1, 0, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0);
    check("late_hi", {32'h0, hi}, 64'd0);
    check("late_lo", {32'h0, lo}, 64'd0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] op;
      logic       rn;
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(16, 23));
      else op = 5'($urandom);
      rn = ($urandom_range(0, 299) != 0);
      cyc(rn, pick(), pick(), 5'($urandom), op, ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
